// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, line/frame totals and the
// per-pixel word carried through the output pipeline.
package vga_pkg;

    localparam int unsigned DEF_H_VISIBLE  = 640;
    localparam int unsigned DEF_H_FRONT    = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BACK     = 48;
    localparam int unsigned DEF_V_VISIBLE  = 480;
    localparam int unsigned DEF_V_FRONT    = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BACK     = 33;
    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_PIPE_DELAY = 1;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vga_px_t;

    // Syncs deasserted, blanked, black.
    localparam vga_px_t PX_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, r: 8'h00, g: 8'h00,
                                    b: 8'h00};

    function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of pixel words; resets every stage to the idle pixel.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic    Clk,
    input  logic    Reset_n,
    input  logic    en_i,
    input  vga_px_t d_i,
    output vga_px_t q_o
);

    vga_px_t stage_q [Depth];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= PX_IDLE;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster-scan timing source: pixel-rate divider, X/Y counters, sync/blank decode and a
// registered output pipeline that keeps colour and sync aligned at the DAC pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_ce,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [1:0] DIV_HALF = 2'(CLK_DIV / 2);

    logic [1:0] div_cnt_q, div_cnt_d;
    logic       pixel_ce_q, vga_clk_q, frame_start_q;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       line_end, frame_end;
    logic       hs_c, vs_c, vis_c;
    vga_px_t    px_in, px_out;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? 2'd0 : div_cnt_q + 2'd1;
        line_end  = (x_q == X_LAST);
        frame_end = line_end && (y_q == Y_LAST);
        x_d       = x_q;
        y_d       = y_q;
        if (pixel_ce_q) begin
            x_d = line_end ? 10'd0 : x_q + 10'd1;
            if (line_end) begin
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q     <= 2'd0;
            pixel_ce_q    <= 1'b0;
            vga_clk_q     <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pixel_ce_q    <= (div_cnt_q == DIV_LAST);
            vga_clk_q     <= (div_cnt_q >= DIV_HALF);
            frame_start_q <= pixel_ce_q && frame_end;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    // Colour is blanked before it enters the pipeline so the pins are pure register outputs.
    always_comb begin
        hs_c      = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
        vs_c      = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
        vis_c     = (x_q < X_VIS) && (y_q < Y_VIS);
        px_in.hs  = hs_c;
        px_in.vs  = vs_c;
        px_in.vis = vis_c;
        px_in.r   = vis_c ? R_in : 8'h00;
        px_in.g   = vis_c ? G_in : 8'h00;
        px_in.b   = vis_c ? B_in : 8'h00;
    end

    vga_delay_line #(
        .Depth(PIPE_DELAY)
    ) u_delay (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .en_i   (pixel_ce_q),
        .d_i    (px_in),
        .q_o    (px_out)
    );

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign pixel_ce    = pixel_ce_q;
    assign frame_start = frame_start_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = px_out.hs;
    assign VGA_VS      = px_out.vs;
    assign VGA_BLANK_N = px_out.vis;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = px_out.r;
    assign VGA_G       = px_out.g;
    assign VGA_B       = px_out.b;

endmodule
